// File: rtl/mips_dev_pkg.sv
// Shared definitions for the bridge-attached MIPS devices: register offsets,
// CTRL layout, mode encodings, device base addresses and the timer state enum.
package mips_dev_pkg;

    // Word offsets (Addr[3:2]) within a device slot
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STAT   = 2'd3;

    // CTRL field layout
    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_MODE_LSB = 1;
    localparam int unsigned CTRL_IM_BIT   = 3;
    localparam int unsigned CTRL_W        = 4;

    // MODE encodings; 2'b1x is treated as one-shot
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    // Device slots as decoded by the bridge
    localparam logic [31:0] DEV0_BASE = 32'h0000_7F00;
    localparam logic [31:0] DEV1_BASE = 32'h0000_7F10;

    // CTRL register image, bit 0 = EN
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } timer_state_e;

endpackage

// File: rtl/dev_timer.sv
// Memory-mapped programmable down-counter timer for one bridge device slot.
// Optional status register at offset 3 enabled by DEV_TIMER_STATUS_EN.
module dev_timer
    import mips_dev_pkg::*;
#(
    parameter int unsigned RELOAD_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:2]  Addr,
    input  logic        WE,
    input  logic [31:0] DEV_WD,
    output logic [31:0] DEV_RD,
    output logic        IRQ
);

    ctrl_t                 ctrl_q, ctrl_d;
    logic [RELOAD_W-1:0]   preset_q, preset_d;
    logic [RELOAD_W-1:0]   count_q, count_d;
    logic                  irq_flag_q, irq_flag_d;
    timer_state_e          state_q, state_d;

    logic                  ctrl_wr;
    logic                  preset_wr;

    assign ctrl_wr   = WE && (Addr == REG_CTRL);
    assign preset_wr = WE && (Addr == REG_PRESET);

    // State and register file, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
            state_q    <= ST_IDLE;
        end else begin
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
            state_q    <= state_d;
        end
    end

    // Next-state: FSM first, then bus writes override (software wins over hardware)
    always_comb begin
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;
        state_d    = state_q;

        unique case (state_q)
            ST_IDLE: begin
                if (ctrl_q.en) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                // An auto-reload pulse lives only for the cycle after INT
                count_d    = preset_q;
                irq_flag_d = 1'b0;
                state_d    = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q.en) begin
                    state_d = ST_IDLE;
                end else if (count_q != '0) begin
                    count_d = count_q - RELOAD_W'(1);
                end else begin
                    state_d = ST_INT;
                end
            end
            ST_INT: begin
                irq_flag_d = 1'b1;
                if (ctrl_q.mode == MODE_RELOAD) begin
                    state_d = ST_LOAD;
                end else begin
                    ctrl_d.en = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (ctrl_wr) begin
            ctrl_d     = ctrl_t'(DEV_WD[CTRL_W-1:0]);
            irq_flag_d = 1'b0;
        end
        if (preset_wr) begin
            preset_d = DEV_WD[RELOAD_W-1:0];
        end
`ifdef DEV_TIMER_STATUS_EN
        if (WE && (Addr == REG_STAT) && DEV_WD[1]) begin
            irq_flag_d = 1'b0;
        end
`endif
    end

    // Combinational read mux, narrow registers zero-extended
    always_comb begin
        DEV_RD = '0;
        unique case (Addr)
            REG_CTRL:   DEV_RD = 32'(ctrl_q);
            REG_PRESET: DEV_RD = 32'(preset_q);
            REG_COUNT:  DEV_RD = 32'(count_q);
`ifdef DEV_TIMER_STATUS_EN
            REG_STAT:   DEV_RD = {30'b0, irq_flag_q, (state_q != ST_IDLE)};
`else
            REG_STAT:   DEV_RD = '0;
`endif
            default:    DEV_RD = '0;
        endcase
    end

    assign IRQ = irq_flag_q & ctrl_q.im;

endmodule

// File: tb/tb_dev_timer.sv
// Scoreboard bench for dev_timer: expectations are queued as stimulus is
// applied and popped when the corresponding DUT output is sampled.
module tb_dev_timer;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] dev_wd;
    logic [31:0] dev_rd;
    logic        irq;

    int n_total;
    int n_bad;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    dev_timer #(.RELOAD_W(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .Addr   (addr),
        .WE     (we),
        .DEV_WD (dev_wd),
        .DEV_RD (dev_rd),
        .IRQ    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] got);
        exp_t e;
        if (sb.size() == 0) begin
            check_val("sb_underflow", got, 32'hDEAD_BEEF);
        end else begin
            e = sb.pop_front();
            check_val(e.tag, got, e.val);
        end
    endtask

    // Advance one clock, land 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Bus write committing on the next rising edge
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr   = a;
        dev_wd = d;
        we     = 1'b1;
        tick();
        we     = 1'b0;
        dev_wd = '0;
    endtask

    task automatic exp_rd(input string tag, input logic [1:0] a, input logic [31:0] v);
        sb_push(tag, v);
        addr = a;
        #1;
        sb_pop(dev_rd);
    endtask

    task automatic exp_irq(input string tag, input logic v);
        sb_push(tag, 32'(v));
        sb_pop(32'(irq));
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        reset   = 1'b1;
        we      = 1'b0;
        addr    = 2'd0;
        dev_wd  = '0;
        ticks(2);
        reset = 1'b0;
        tick();

        // Reset state
        exp_rd("rst_ctrl", 2'd0, 32'h0);
        exp_rd("rst_preset", 2'd1, 32'h0);
        exp_rd("rst_count", 2'd2, 32'h0);
        exp_rd("rst_stat", 2'd3, 32'h0);
        exp_irq("rst_irq", 1'b0);

        // One-shot, PRESET=3
        wr(2'd1, 32'd3);
        exp_rd("os_preset", 2'd1, 32'd3);
        wr(2'd0, 32'h9);                       // E0
        tick();                                // E1
        for (int k = 2; k <= 5; k++) begin
            tick();
            exp_rd($sformatf("os_count_e%0d", k), 2'd2, 32'(5 - k));
            exp_irq($sformatf("os_irq_e%0d", k), 1'b0);
        end
        tick();                                // E6: INT
        exp_irq("os_irq_e6", 1'b0);
        tick();                                // E7
        exp_irq("os_irq_e7", 1'b1);
        exp_rd("os_ctrl_en_clr", 2'd0, 32'h8);
        exp_rd("os_count_hold", 2'd2, 32'h0);
`ifdef DEV_TIMER_STATUS_EN
        exp_rd("os_stat", 2'd3, 32'h2);
        wr(2'd3, 32'h2);
        exp_rd("os_stat_clr", 2'd3, 32'h0);
        exp_irq("os_irq_stat_clr", 1'b0);
        exp_rd("os_ctrl_kept", 2'd0, 32'h8);
`else
        exp_rd("os_stat", 2'd3, 32'h0);
        wr(2'd3, 32'h2);
        exp_irq("os_irq_stat_ign", 1'b1);
`endif
        wr(2'd0, 32'h0);
        exp_irq("os_irq_ack", 1'b0);

        // Auto-reload, PRESET=2: pulses after E6, E11, E16
        wr(2'd1, 32'd2);
        wr(2'd0, 32'hB);                       // E0
        for (int k = 1; k <= 17; k++) begin
            tick();
            exp_irq($sformatf("ar_irq_e%0d", k), (k == 6) || (k == 11) || (k == 16));
        end
        exp_rd("ar_ctrl", 2'd0, 32'hB);
        wr(2'd0, 32'h0);
        ticks(6);
        exp_irq("ar_irq_off", 1'b0);

        // Disable mid-count freezes COUNT, re-enable reloads
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h1);                       // E0
        ticks(5);                              // E5
        exp_rd("frz_count_e5", 2'd2, 32'd7);
        wr(2'd0, 32'h0);                       // E6: last decrement
        exp_rd("frz_count_e6", 2'd2, 32'd6);
        ticks(3);
        exp_rd("frz_count_hold", 2'd2, 32'd6);
        wr(2'd2, 32'h55);
        exp_rd("frz_count_wr_ign", 2'd2, 32'd6);
        wr(2'd0, 32'h1);
        ticks(2);
        exp_rd("frz_reload", 2'd2, 32'd10);
        wr(2'd0, 32'h0);
        ticks(3);

        // CTRL write on the one-shot INT exit edge; then mode 1x one-shot
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h9);                       // E0
        ticks(4);                              // E4: INT
        exp_irq("coll_irq_e4", 1'b0);
        wr(2'd0, 32'hD);                       // E5
        exp_rd("coll_ctrl", 2'd0, 32'hD);
        exp_irq("coll_irq_e5", 1'b0);
        for (int k = 6; k <= 9; k++) begin
            tick();
            exp_irq($sformatf("coll_irq_e%0d", k), 1'b0);
        end
        tick();                                // E10
        exp_irq("m1x_irq", 1'b1);
        exp_rd("m1x_ctrl", 2'd0, 32'hC);
        wr(2'd0, 32'h0);

        // PRESET=0: one CNT cycle then INT
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);                       // E0
        ticks(3);
        exp_irq("p0_irq_e3", 1'b0);
        tick();
        exp_irq("p0_irq_e4", 1'b1);
        wr(2'd0, 32'h0);
        exp_irq("p0_irq_ack", 1'b0);

        // Asynchronous reset mid-count
        wr(2'd1, 32'd8);
        wr(2'd0, 32'h9);                       // E0
        ticks(5);
        exp_rd("mr_count_pre", 2'd2, 32'd5);
`ifdef DEV_TIMER_STATUS_EN
        exp_rd("mr_busy", 2'd3, 32'h1);
`endif
        reset = 1'b1;
        exp_rd("mr_count", 2'd2, 32'h0);
        exp_rd("mr_ctrl", 2'd0, 32'h0);
        exp_rd("mr_preset", 2'd1, 32'h0);
        exp_rd("mr_stat", 2'd3, 32'h0);
        exp_irq("mr_irq", 1'b0);
        tick();
        reset = 1'b0;
        ticks(12);
        exp_irq("mr_irq_later", 1'b0);
        exp_rd("mr_count_later", 2'd2, 32'h0);

        if (sb.size() != 0) check_val("sb_leftover", 32'(sb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/dev_timer.md
Name: dev_timer

Overview:
- Memory-mapped programmable down-counter timer, one instance per device slot behind the system bridge.
- Slots: DEV0 at 0x00007F00, DEV1 at 0x00007F10.
- Consumes the bridge's decoded word address, write data and per-device write enable. Returns read data and one interrupt request, which the bridge folds into HWInt[7:2].

Parameters:
- RELOAD_W, 32, width of PRESET and COUNT registers (1..32; upper bits of reads zero-extended).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- Addr  input  2 [3:2]  word offset from the bridge
- WE  input  1  write enable for this device from the bridge
- DEV_WD  input  32  write data from the bridge
- DEV_RD  output  32  combinational read data to the bridge
- IRQ  output  1  interrupt request to the bridge

Behaviour:
- Register map (Addr):
  - 0 = CTRL: bit0 EN, bits2:1 MODE, bit3 IM; upper bits write-ignored, read 0.
  - 1 = PRESET: read/write.
  - 2 = COUNT: read-only.
  - 3 = reads 0.
- Writes to Addr 2 and 3 are ignored.
- Reset: CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE, IRQ=0. DEV_RD follows Addr with those values.
- Writes commit on the rising edge when WE=1. Reads are combinational, with no latency.
- MODE 00 = one-shot. MODE 01 = auto-reload. MODE 1x behaves as one-shot.
- FSM states IDLE, LOAD, CNT, INT:
  - IDLE: EN=1 -> LOAD; else hold. COUNT holds its value.
  - LOAD: COUNT<=PRESET -> CNT.
  - CNT: EN=0 -> IDLE, COUNT frozen. COUNT!=0 -> COUNT<=COUNT-1. COUNT==0 -> INT.
  - INT, one-shot: irq_flag<=1, EN<=0 -> IDLE.
  - INT, auto-reload: irq_flag high for this one cycle only -> LOAD.
- IRQ = irq_flag & IM.
- One-shot: irq_flag stays set until any CTRL write (acknowledge).
- Timing, for CTRL write (EN=1) on edge E0 with PRESET=N:
  - LOAD after E1; COUNT=N after E2.
  - COUNT=0 after E(N+2); INT after E(N+3).
  - One-shot: IRQ high after E(N+4).
  - Auto-reload: IRQ pulse period = N+3 cycles, width 1.
- PRESET=0 is legal: CNT lasts one cycle, then INT.
- A PRESET write during CNT does not disturb COUNT; it takes effect at the next LOAD.
- CTRL write on the same edge the FSM leaves INT (one-shot):
  - The written CTRL value wins over the hardware EN clear.
  - irq_flag stays 0 (the acknowledge wins).
  - The FSM goes to IDLE, then follows the written EN.
- A CTRL write with EN=0 in LOAD or INT completes that state; the FSM then observes EN=0 and goes to IDLE.
- Reset asserted mid-count returns everything to reset values immediately, with no pending IRQ.
- COUNT never wraps: decrement is gated at 0.

Optional Feature:
- Macro: DEV_TIMER_STATUS_EN.
- Defined:
  - Addr 3 reads {30'b0, irq_flag, busy}, where busy = (state != IDLE).
  - A write to Addr 3 with DEV_WD[1]=1 clears irq_flag without touching CTRL.
  - An Addr 3 write on the same edge irq_flag would be set: the clear wins.
- Undefined: Addr 3 reads 0 and writes are ignored.

Decomposition:
- Shared package mips_dev_pkg:
  - Register offset constants (CTRL=2'd0, PRESET=2'd1, COUNT=2'd2, STAT=2'd3).
  - CTRL bit positions and MODE encodings.
  - Device base addresses 0x00007F00 and 0x00007F10, shared with the bridge.
  - Timer state enum.
- No sub-module: the FSM, register file and counter stay in one module.

Test Plan:
- Reset, then read Addr 0/1/2 -> all 0, IRQ=0. Assert reset mid-count (COUNT=5) -> COUNT=0, state IDLE, IRQ=0 the same cycle.
- PRESET=3, CTRL=0x9 (EN, one-shot, IM) at E0 -> COUNT reads 3,2,1,0 after E2..E5; IRQ rises after E7; EN reads 0. Writing CTRL=0 drops IRQ next cycle.
- PRESET=2, CTRL=0xB (auto-reload, IM) -> IRQ one-cycle pulses every 5 cycles; at least 3 periods checked; EN stays 1.
- PRESET=10, enable, write CTRL=0 when COUNT=6 -> COUNT frozen at 6. Re-enable -> reload to 10.
- CTRL write coinciding with the one-shot INT cycle -> written value readback; IRQ never asserts.
- With DEV_TIMER_STATUS_EN: one-shot expiry -> Addr 3 reads 0x2. Write 0x2 to Addr 3 -> reads 0x0, IRQ low. Without the macro: Addr 3 reads 0.
